// File: rtl/data_mem_pkg.sv
// Shared types for the handshaked data memory: access sizes, FSM states, wait-counter width.
package data_mem_pkg;

    localparam int unsigned CntWidth = 4;

    typedef enum logic [1:0] {
        SizeByte = 2'b00,
        SizeHalf = 2'b01,
        SizeWord = 2'b10,
        SizeRsvd = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    // Byte offset of the lane inside the word; half/word drop the low address bits.
    function automatic logic [1:0] lane_off(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SizeByte: return addr_lo;
            SizeHalf: return {addr_lo[1], 1'b0};
            default:  return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response bus of data_mem_hs. rsp_err exists only when DATA_MEM_ERR_EN is defined.
interface data_mem_hs_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
`ifdef DATA_MEM_ERR_EN
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
`else
    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );
    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
`endif

endinterface

// File: rtl/load_align.sv
// Combinational load lane extraction with sign or zero extension.
module load_align
    import data_mem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  size_e       i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_data
);

    logic [31:0] w_shift;

    assign w_shift = i_word >> {i_off, 3'b000};

    always_comb begin
        o_data = i_word;
        case (i_size)
            SizeByte: o_data = {{24{~i_unsigned & w_shift[7]}}, w_shift[7:0]};
            SizeHalf: o_data = {{16{~i_unsigned & w_shift[15]}}, w_shift[15:0]};
            default:  o_data = i_word;
        endcase
    end

endmodule

// File: rtl/data_mem_hs.sv
// Word-organised data memory behind a valid/ready request/response handshake with fixed wait
// states. Define DATA_MEM_ERR_EN to flag misaligned or out-of-range accesses on rsp_err.
module data_mem_hs
    import data_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned WAIT_STATES = 2
) (
    input logic         clk,
    input logic         rst,
    data_mem_hs_if.slave bus
);

    localparam int unsigned           IdxWidth  = $clog2(DEPTH_WORDS);
    localparam logic [32:0]           SpanBytes = 33'(4 * DEPTH_WORDS);
    localparam logic [CntWidth-1:0]   CntLoad   =
        (WAIT_STATES == 0) ? '0 : CntWidth'(WAIT_STATES - 1);

    state_e              r_state, w_state_d;
    logic [CntWidth-1:0] r_cnt, w_cnt_d;
    logic                r_we, r_unsigned;
    size_e               r_size;
    logic [31:0]         r_addr, r_wdata, r_rdata;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_accept, w_enter_resp, w_ok;
    logic                w_we, w_unsigned;
    size_e               w_size;
    logic [31:0]         w_addr, w_wdata, w_diff, w_wdat, w_load, w_rsp_rdata;
    logic [IdxWidth-1:0] w_idx;
    logic [1:0]          w_off;
    logic [3:0]          w_be;

    assign w_accept = (r_state == StIdle) && bus.req_valid;

    // With zero wait states the access completes on the accept edge, so use the live request.
    assign w_we       = (r_state == StIdle) ? bus.req_we : r_we;
    assign w_size     = (r_state == StIdle) ? size_e'(bus.req_size) : r_size;
    assign w_unsigned = (r_state == StIdle) ? bus.req_unsigned : r_unsigned;
    assign w_addr     = (r_state == StIdle) ? bus.req_addr : r_addr;
    assign w_wdata    = (r_state == StIdle) ? bus.req_wdata : r_wdata;

    assign w_diff = w_addr - BASE_ADDR;
    assign w_idx  = w_diff[IdxWidth+1:2];
    assign w_off  = lane_off(w_size, w_addr[1:0]);

`ifdef DATA_MEM_ERR_EN
    logic r_err, w_misalign;

    assign w_misalign = ((w_size == SizeHalf) && w_addr[0]) ||
                        (((w_size == SizeWord) || (w_size == SizeRsvd)) && (|w_addr[1:0]));
    assign w_ok        = !w_misalign && ({1'b0, w_diff} < SpanBytes);
    assign bus.rsp_err = r_err;
`else
    logic w_unused;

    assign w_ok     = 1'b1;
    assign w_unused = ^{w_diff[31:IdxWidth+2], w_diff[1:0], SpanBytes};
`endif

    always_comb begin
        w_state_d    = r_state;
        w_cnt_d      = r_cnt;
        w_enter_resp = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.req_valid) begin
                    if (WAIT_STATES == 0) begin
                        w_state_d    = StResp;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_d = StWait;
                        w_cnt_d   = CntLoad;
                    end
                end
            end
            StWait: begin
                if (r_cnt == '0) begin
                    w_state_d    = StResp;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StResp: begin
                if (bus.rsp_ready) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_be   = 4'hf;
        w_wdat = w_wdata;
        case (w_size)
            SizeByte: begin
                w_be   = 4'b0001 << w_off;
                w_wdat = {4{w_wdata[7:0]}};
            end
            SizeHalf: begin
                w_be   = 4'b0011 << w_off;
                w_wdat = {2{w_wdata[15:0]}};
            end
            default: w_be = 4'hf;
        endcase
    end

    load_align u_load_align (
        .i_word     (r_mem[w_idx]),
        .i_off      (w_off),
        .i_size     (w_size),
        .i_unsigned (w_unsigned),
        .o_data     (w_load)
    );

    assign w_rsp_rdata = (w_we || !w_ok) ? 32'h0 : w_load;

    assign bus.req_ready = (r_state == StIdle);
    assign bus.rsp_valid = (r_state == StResp);
    assign bus.rsp_rdata = r_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_we       <= 1'b0;
            r_size     <= SizeByte;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
`ifdef DATA_MEM_ERR_EN
            r_err      <= 1'b0;
`endif
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_accept) begin
                r_we       <= bus.req_we;
                r_size     <= size_e'(bus.req_size);
                r_unsigned <= bus.req_unsigned;
                r_addr     <= bus.req_addr;
                r_wdata    <= bus.req_wdata;
            end
            if (w_enter_resp) begin
                r_rdata <= w_rsp_rdata;
`ifdef DATA_MEM_ERR_EN
                r_err   <= !w_ok;
`endif
            end
        end
    end

    // Contents survive reset; a store only lands on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (!rst && w_enter_resp && w_we && w_ok) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdat[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: a 2-wait-state instance and a 0-wait-state, 16-word instance.
module tb_data_mem_hs;

    localparam logic [31:0] Base = 32'h1001_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    data_mem_hs_if bus2 ();
    data_mem_hs_if bus0 ();

    data_mem_hs #(.WAIT_STATES(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    data_mem_hs #(.DEPTH_WORDS(16), .WAIT_STATES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full transaction on the 2-wait-state instance with rsp_ready held high.
    task automatic req2(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        bus2.req_valid    = 1'b1;
        bus2.req_we       = we;
        bus2.req_size     = size;
        bus2.req_unsigned = uns;
        bus2.req_addr     = addr;
        bus2.req_wdata    = wdata;
        bus2.rsp_ready    = 1'b1;
        check("req_ready before accept", 32'(bus2.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        lat = 1;
        while (!bus2.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata = bus2.rsp_rdata;
`ifdef DATA_MEM_ERR_EN
        err = bus2.rsp_err;
`else
        err = 1'b0;
`endif
    endtask

    task automatic ld(input string tag, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        logic        er;
        int          lat;
        req2(1'b0, size, uns, addr, 32'h0, rd, er, lat);
        check(tag, rd, exp);
        check({tag, " latency"}, 32'(lat), 32'd3);
`ifdef DATA_MEM_ERR_EN
        check({tag, " err"}, 32'(er), 32'd0);
`endif
    endtask

    task automatic st(input string tag, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] data);
        logic [31:0] rd;
        logic        er;
        int          lat;
        req2(1'b1, size, 1'b0, addr, data, rd, er, lat);
        check({tag, " rdata"}, rd, 32'h0);
        check({tag, " latency"}, 32'(lat), 32'd3);
`ifdef DATA_MEM_ERR_EN
        check({tag, " err"}, 32'(er), 32'd0);
`endif
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;

        rst = 1'b1;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_size = 2'b00;
        bus2.req_unsigned = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
        bus2.rsp_ready = 1'b1;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_size = 2'b00;
        bus0.req_unsigned = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
        bus0.rsp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(bus2.req_ready), 32'd1);
        check("reset rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        check("reset rsp_rdata", bus2.rsp_rdata, 32'h0);
        check("reset req_ready w0", 32'(bus0.req_ready), 32'd1);
        check("reset rsp_valid w0", 32'(bus0.rsp_valid), 32'd0);
        rst = 1'b0;

        st("sw cafebabe", 2'b10, Base, 32'hCAFE_BABE);
        ld("lw cafebabe", 2'b10, 1'b0, Base, 32'hCAFE_BABE);
        st("sb 80", 2'b00, Base + 3, 32'hFFFF_FF80);
        ld("lb 80", 2'b00, 1'b0, Base + 3, 32'hFFFF_FF80);
        ld("lbu 80", 2'b00, 1'b1, Base + 3, 32'h0000_0080);
        ld("lw after sb", 2'b10, 1'b0, Base, 32'h80FE_BABE);
        st("sh beef", 2'b01, Base + 2, 32'h1234_BEEF);
        ld("lh hi", 2'b01, 1'b0, Base + 2, 32'hFFFF_BEEF);
        ld("lhu hi", 2'b01, 1'b1, Base + 2, 32'h0000_BEEF);
        ld("lh lo", 2'b01, 1'b0, Base, 32'hFFFF_BABE);
        ld("lb byte1", 2'b00, 1'b0, Base + 1, 32'hFFFF_FFBA);
        ld("lbu byte0", 2'b00, 1'b1, Base, 32'h0000_00BE);
        st("sw word2", 2'b10, Base + 8, 32'h7F00_FF01);
        ld("lh word2", 2'b01, 1'b0, Base + 8, 32'hFFFF_FF01);
        ld("lbu word2 b3", 2'b00, 1'b1, Base + 11, 32'h0000_007F);
        ld("lw word0 kept", 2'b10, 1'b0, Base, 32'hBEEF_BABE);

        // Response backpressure
        @(negedge clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_size = 2'b10;
        bus2.req_unsigned = 1'b0; bus2.req_addr = Base; bus2.rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        lat = 1;
        while (!bus2.rsp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("stall latency", 32'(lat), 32'd3);
        for (int i = 0; i < 5; i++) begin
            check("stall rsp_valid", 32'(bus2.rsp_valid), 32'd1);
            check("stall rsp_rdata", bus2.rsp_rdata, 32'hBEEF_BABE);
            check("stall req_ready", 32'(bus2.req_ready), 32'd0);
            @(negedge clk);
        end
        bus2.rsp_ready = 1'b1;
        check("handshake cycle req_ready", 32'(bus2.req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("after handshake rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        check("after handshake req_ready", 32'(bus2.req_ready), 32'd1);

        // Reset while a store waits
        bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_size = 2'b10;
        bus2.req_addr = Base; bus2.req_wdata = 32'h1234_5678;
        @(posedge clk);
        @(negedge clk);
        bus2.req_valid = 1'b0;
        check("in wait req_ready", 32'(bus2.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("rst mid wait req_ready", 32'(bus2.req_ready), 32'd1);
        check("rst mid wait rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post rst rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        ld("lw after aborted sw", 2'b10, 1'b0, Base, 32'hBEEF_BABE);

        // Misaligned and out-of-range accesses
`ifdef DATA_MEM_ERR_EN
        req2(1'b0, 2'b10, 1'b0, Base + 2, 32'h0, rd, er, lat);
        check("lw misaligned err", 32'(er), 32'd1);
        check("lw misaligned rdata", rd, 32'h0);
        check("lw misaligned latency", 32'(lat), 32'd3);
        req2(1'b1, 2'b00, 1'b0, Base + 32'h1000, 32'h55, rd, er, lat);
        check("sb out of range err", 32'(er), 32'd1);
        ld("lw after faulted sb", 2'b10, 1'b0, Base, 32'hBEEF_BABE);
`else
        ld("lw misaligned forced", 2'b10, 1'b0, Base + 2, 32'hBEEF_BABE);
        ld("lh odd forced", 2'b01, 1'b0, Base + 3, 32'hFFFF_BEEF);
        ld("lw wrapped", 2'b10, 1'b0, Base + 32'h1000, 32'hBEEF_BABE);
        st("sb wrapped", 2'b00, Base + 32'h1000, 32'h55);
        ld("lw after wrapped sb", 2'b10, 1'b0, Base, 32'hBEEF_BA55);
`endif

        // Zero wait states: one-cycle latency, accept every second cycle
        @(negedge clk);
        bus0.req_valid = 1'b1; bus0.req_we = 1'b1; bus0.req_size = 2'b10;
        bus0.req_addr = Base + 4; bus0.req_wdata = 32'hA5A5_A5A5; bus0.rsp_ready = 1'b1;
        check("w0 ready c0", 32'(bus0.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        check("w0 sw rsp_valid c1", 32'(bus0.rsp_valid), 32'd1);
        check("w0 sw rdata", bus0.rsp_rdata, 32'h0);
        check("w0 ready c1", 32'(bus0.req_ready), 32'd0);
        bus0.req_we = 1'b0; bus0.req_unsigned = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("w0 rsp_valid c2", 32'(bus0.rsp_valid), 32'd0);
        check("w0 ready c2", 32'(bus0.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus0.req_valid = 1'b0;
        check("w0 lw rsp_valid c3", 32'(bus0.rsp_valid), 32'd1);
        check("w0 lw rdata", bus0.rsp_rdata, 32'hA5A5_A5A5);
        @(posedge clk);
        @(negedge clk);
        check("w0 idle rsp_valid", 32'(bus0.rsp_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_hs.md
DATA_MEM_HS -- requirements
Module: data_mem_hs

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning word count; power of two, minimum 4.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h10010000, meaning byte address of word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 2, meaning extra cycles per access; legal range 0..15.
REQ-004 SHALL have port clk  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  block can accept a request.
REQ-008 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-009 SHALL have port req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-010 SHALL have port req_unsigned  input  1  zero-extend load if 1, sign-extend if 0.
REQ-011 SHALL have port req_addr  input  32  byte address.
REQ-012 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-013 SHALL have port rsp_valid  output  1  response present.
REQ-014 SHALL have port rsp_ready  input  1  consumer accepts response.
REQ-015 SHALL have port rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores.
REQ-016 SHALL have port rsp_err  output  1  access fault; present only with DATA_MEM_ERR_EN.

Function
REQ-017 SHALL implement FSM IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL accept a request on the rising edge with req_valid && req_ready and register all req_* fields.
REQ-019 SHALL go IDLE->WAIT on accept when WAIT_STATES > 0, else IDLE->RESP directly.
REQ-020 SHALL stay in WAIT for exactly WAIT_STATES cycles via a down-counter, then enter RESP.
REQ-021 SHALL assert rsp_valid exactly 1+WAIT_STATES cycles after the accept edge.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_err stable until rsp_ready; go RESP->IDLE on rsp_valid && rsp_ready.
REQ-023 SHALL NOT accept a new request in the cycle the response handshakes; the next accept occurs in IDLE at the earliest one cycle later.
REQ-024 SHALL commit a store on the edge that enters RESP, writing only the byte lanes selected by size and addr[1:0].
REQ-025 SHALL read a load on the edge entering RESP, extract the lane and extend per req_unsigned.
REQ-026 SHALL compute word index = ((addr - BASE_ADDR) >> 2) mod DEPTH_WORDS.
REQ-027 SHALL have rsp_rdata = 0 for every store response.

Reset
REQ-028 SHALL on rst force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 1.
REQ-029 SHALL discard an accepted but uncommitted store when rst asserts mid-operation; memory unchanged.
REQ-030 SHALL NOT clear memory contents on reset.

Configuration
REQ-031 SHALL, with DATA_MEM_ERR_EN defined, set rsp_err = 1 for a misaligned access (half at odd address, word not 4-aligned) or an address outside BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1.
REQ-032 SHALL, with DATA_MEM_ERR_EN defined, suppress the write on a faulted store, return rsp_rdata = 0, and keep the same latency.
REQ-033 SHALL, without DATA_MEM_ERR_EN, omit rsp_err, force alignment (half ignores addr[0], word ignores addr[1:0]) and wrap the index modulo DEPTH_WORDS.

Structure
REQ-034 SHALL take size encodings, the FSM state enum and the 4-bit wait-counter width from the shared package data_mem_pkg.
REQ-035 SHALL place lane extraction and sign/zero extension in sub-module load_align, which is combinational.

Verification
REQ-036 SHALL cover: WAIT_STATES=2, store word 32'hCAFEBABE @ 0x10010000, rsp_ready=1 -> rsp_valid 3 cycles after accept; a following load returns 32'hCAFEBABE.
REQ-037 SHALL cover: sb 8'h80 @ 0x10010003, then lb -> 32'hFFFFFF80 and lbu -> 32'h00000080; other bytes unchanged.
REQ-038 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready 0 throughout.
REQ-039 SHALL cover: rst pulsed during WAIT of store 32'h12345678 -> IDLE, rsp_valid 0, later load returns the old value.
REQ-040 SHALL cover: with DATA_MEM_ERR_EN, lw @ 0x10010002 -> rsp_err 1, rdata 0; without it, the same load returns the word at 0x10010000.
REQ-041 SHALL cover: WAIT_STATES=0 -> rsp_valid 1 cycle after accept; back-to-back requests accepted every 2 cycles.
